// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the fetch PC generator.
//   pc_t        - 32-bit program counter
//   redirect_t  - {enable, pc_new} selected redirect request
//   *_DEF       - default reset / exception vectors
//   block_base_next() - base of the fetch block following a given pc
package pc_gen_pkg;

    typedef logic [31:0] pc_t;

    typedef struct packed {
        logic enable;
        pc_t  pc_new;
    } redirect_t;

    localparam pc_t RESET_VECTOR_DEF = 32'hBFC0_0000;
    localparam pc_t EXC_VECTOR_DEF   = 32'hBFC0_0380;

    // Align pc down to a block boundary, then step one block; wraps modulo 2^32.
    function automatic pc_t block_base_next(pc_t cur, pc_t block_bytes);
        pc_t mask;
        mask = ~(block_bytes - pc_t'(1));
        return (cur & mask) + block_bytes;
    endfunction

endpackage

// File: rtl/redirect_arbiter.sv
// redirect_arbiter: fixed-priority selection among redirect channels.
// Ports:
//   redirect_valid - per-channel request, index 0 has highest priority
//   redirect_pc    - per-channel target
//   grant_valid    - at least one channel requested
//   grant_pc       - target of the lowest-index requesting channel
module redirect_arbiter #(
    parameter int unsigned NUM_REDIRECT = 3
) (
    input  logic [NUM_REDIRECT-1:0]       redirect_valid,
    input  logic [NUM_REDIRECT-1:0][31:0] redirect_pc,
    output logic                          grant_valid,
    output logic [31:0]                   grant_pc
);

    // Walk from lowest priority to highest so the last hit (lowest index) wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_pc    = '0;
        for (int i = int'(NUM_REDIRECT) - 1; i >= 0; i--) begin
            if (redirect_valid[i]) begin
                grant_valid = 1'b1;
                grant_pc    = redirect_pc[i];
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with prioritised redirects.
// Optional feature macro: PC_GEN_ALIGN_CHECK_EN (trap on misaligned redirect target;
// when undefined, target bits [1:0] are cleared and misalign/bad_pc read 0).
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   redirect_valid  - per-channel redirect request (index 0 highest priority)
//   redirect_pc     - per-channel redirect target
//   pc_ready        - fetch accepts current pc
//   pc, pc_valid    - offered fetch address
//   slot_mask       - slots from pc to the end of its fetch block
//   epoch           - redirect generation tag
//   flush           - one-cycle pulse after each accepted redirect
//   misalign        - one-cycle trap pulse
//   bad_pc          - last misaligned target
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned NUM_REDIRECT = 3,
    parameter int unsigned FETCH_WIDTH  = 2,
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter int unsigned EPOCH_W      = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REDIRECT-1:0]       redirect_valid,
    input  logic [NUM_REDIRECT-1:0][31:0] redirect_pc,
    input  logic                          pc_ready,
    output logic [31:0]                   pc,
    output logic                          pc_valid,
    output logic [FETCH_WIDTH-1:0]        slot_mask,
    output logic [EPOCH_W-1:0]            epoch,
    output logic                          flush,
    output logic                          misalign,
    output logic [31:0]                   bad_pc
);

    localparam pc_t BLOCK_BYTES = pc_t'(4 * FETCH_WIDTH);

    redirect_t grant;
    pc_t       pc_q, pc_d;
    logic      valid_q;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic      flush_q, flush_d;
    pc_t       slot_idx;

    redirect_arbiter #(
        .NUM_REDIRECT (NUM_REDIRECT)
    ) u_redirect_arbiter (
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .grant_valid    (grant.enable),
        .grant_pc       (grant.pc_new)
    );

`ifdef PC_GEN_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    pc_t  bad_pc_q, bad_pc_d;
`else
    logic unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;
`endif

    always_comb begin
        pc_d    = pc_q;
        epoch_d = epoch_q;
        flush_d = 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
        misalign_d = 1'b0;
        bad_pc_d   = bad_pc_q;
`endif
        // A redirect wins over the sequential path and ignores pc_ready.
        if (grant.enable) begin
            epoch_d = epoch_q + EPOCH_W'(1);
            flush_d = 1'b1;
`ifdef PC_GEN_ALIGN_CHECK_EN
            if (grant.pc_new[1:0] != 2'b00) begin
                pc_d       = EXC_VECTOR;
                bad_pc_d   = grant.pc_new;
                misalign_d = 1'b1;
            end else begin
                pc_d = grant.pc_new;
            end
`else
            pc_d = {grant.pc_new[31:2], 2'b00};
`endif
        end else if (valid_q && pc_ready) begin
            pc_d = block_base_next(pc_q, BLOCK_BYTES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            epoch_q <= '0;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
            epoch_q <= epoch_d;
            flush_q <= flush_d;
        end
    end

`ifdef PC_GEN_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
            bad_pc_q   <= '0;
        end else begin
            misalign_q <= misalign_d;
            bad_pc_q   <= bad_pc_d;
        end
    end
    assign misalign = misalign_q;
    assign bad_pc   = bad_pc_q;
`else
    assign misalign = 1'b0;
    assign bad_pc   = '0;
`endif

    // Word index of pc within its fetch block.
    assign slot_idx = (pc_q >> 2) & pc_t'(FETCH_WIDTH - 1);

    for (genvar i = 0; i < int'(FETCH_WIDTH); i++) begin : g_slot
        assign slot_mask[i] = (pc_t'(i) >= slot_idx);
    end

    assign pc       = pc_q;
    assign pc_valid = valid_q;
    assign epoch    = epoch_q;
    assign flush    = flush_q;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter NUM_REDIRECT, default 3: number of redirect channels; index 0 has highest priority.
REQ-002 SHALL have parameter FETCH_WIDTH, default 2: instructions per fetch block; power of two, 1..8.
REQ-003 SHALL have parameter RESET_VECTOR, default 32'hBFC0_0000: PC after reset.
REQ-004 SHALL have parameter EXC_VECTOR, default 32'hBFC0_0380: misalignment trap target.
REQ-005 SHALL have parameter EPOCH_W, default 3: epoch counter width.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port redirect_valid, input, NUM_REDIRECT: per-channel redirect request.
REQ-009 SHALL have port redirect_pc, input, NUM_REDIRECT x 32: per-channel target.
REQ-010 SHALL have port pc_ready, input, 1: fetch accepts current pc.
REQ-011 SHALL have port pc, output, 32: current fetch address.
REQ-012 SHALL have port pc_valid, output, 1: pc is offered to fetch.
REQ-013 SHALL have port slot_mask, output, FETCH_WIDTH: slots from pc to end of its fetch block.
REQ-014 SHALL have port epoch, output, EPOCH_W: redirect generation tag.
REQ-015 SHALL have port flush, output, 1: one-cycle pulse after each accepted redirect.
REQ-016 SHALL have port misalign, output, 1: one-cycle trap pulse.
REQ-017 SHALL have port bad_pc, output, 32: last misaligned target.

Function
REQ-018 SHALL offer pc whenever pc_valid=1; pc SHALL hold while pc_valid=1 and pc_ready=0, except on a redirect.
REQ-019 SHALL, on handshake (pc_valid and pc_ready) with no redirect, load the next fetch-block base: pc aligned down to 4*FETCH_WIDTH bytes, plus 4*FETCH_WIDTH, modulo 2^32.
REQ-020 SHALL wrap 32'hFFFF_FFF8 to 32'h0000_0000 for FETCH_WIDTH=2.
REQ-021 SHALL select only the lowest-index asserted redirect_valid; all other channels that cycle are dropped.
REQ-022 SHALL load a redirect target on the next edge regardless of pc_ready; redirect overrides the sequential path.
REQ-023 SHALL increment epoch modulo 2^EPOCH_W once per accepted redirect, in the same edge the new pc loads.
REQ-024 SHALL assert flush for exactly the one cycle following the edge that accepts a redirect.
REQ-025 SHALL keep flush high across back-to-back redirects, with epoch advancing each cycle.
REQ-026 SHALL drive slot_mask bit i high if and only if slot i of the block lies at or after pc[log2(4*FETCH_WIDTH)-1:2].

Reset
REQ-027 SHALL, while rst_n=0, force pc=RESET_VECTOR, pc_valid=0, epoch=0, flush=0, misalign=0, bad_pc=0, asynchronously.
REQ-028 SHALL raise pc_valid on the first rising edge after rst_n deasserts and keep it high thereafter.
REQ-029 SHALL discard any handshake or redirect in progress when reset asserts mid-operation.

Configuration
REQ-030 SHALL, when PC_GEN_ALIGN_CHECK_EN is defined, treat a selected target with bits [1:0] != 0 as a trap: pc loads EXC_VECTOR, bad_pc latches the target, misalign pulses one cycle, epoch increments and flush pulses.
REQ-031 SHALL, when PC_GEN_ALIGN_CHECK_EN is undefined, clear target bits [1:0] and load the result, with misalign and bad_pc tied to 0.

Structure
REQ-032 SHALL take the PC typedef, a REDIRECT struct {enable, pc_new} and vector constants from the shared defines package.
REQ-033 SHALL place channel selection in sub-module redirect_arbiter: a parametrised fixed-priority encoder returning a grant-valid flag and the winning target.

Verification
REQ-034 SHALL check reset release: pc=BFC0_0000 with pc_valid=0 during reset, then pc_valid=1 one cycle after release.
REQ-035 SHALL check sequential fetch (FETCH_WIDTH=2, pc_ready=1): pc 0x1004 -> 0x1008 -> 0x1010; slot_mask=2'b10 at 0x1004 and 2'b11 at 0x1008.
REQ-036 SHALL check the stall path: pc_ready=0 for 5 cycles holds pc=0x2000; a ch2 redirect to 0x3000 during the stall gives pc=0x3000, epoch+1, and a flush pulse.
REQ-037 SHALL check simultaneous redirects: ch0=0x4000 and ch1=0x5000 in the same cycle give pc=0x4000 and a single epoch increment.
REQ-038 SHALL check misalignment with PC_GEN_ALIGN_CHECK_EN: redirect to 0x6002 gives pc=BFC0_0380, bad_pc=0x6002 and a misalign pulse; without the macro, pc=0x6000.
REQ-039 SHALL check wrap-around: pc=0xFFFF_FFF8 with a handshake gives pc=0; eight consecutive redirects wrap epoch back to 0.
